// File: rtl/nvdla_matmul_sched.sv
// nvdla_matmul_sched: round-robin scheduler sharing one nvdla_matrix_mult
// among NUM_REQ requesters.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             per-requester job request / one-hot accept
//   req_rows_a/cols_a/cols_b        packed 32-bit dimensions per requester
//   req_scale/req_apply_scale       packed 16-bit scale and enable per requester
//   rsp_valid/rsp_status            one-hot completion pulse and status code
//   grant_id/grant_active           owning requester (data-mux select), job in flight
//   mm_enable, mm_*                 multiplier start pulse and latched configuration
//   mm_rst_n                        local multiplier reset used for recovery
//   mm_done/mm_error                multiplier status
//   sched_busy/jobs_done            not-idle flag, saturating count of good jobs
module nvdla_matmul_sched #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned MAX_DIM        = 256,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned RST_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_rows_a,
    input  logic [NUM_REQ*32-1:0]      req_cols_a,
    input  logic [NUM_REQ*32-1:0]      req_cols_b,
    input  logic [NUM_REQ*16-1:0]      req_scale,
    input  logic [NUM_REQ-1:0]         req_apply_scale,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [1:0]                 rsp_status,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active,
    output logic                       mm_enable,
    output logic [31:0]                mm_rows_a,
    output logic [31:0]                mm_cols_a,
    output logic [31:0]                mm_cols_b,
    output logic [15:0]                mm_scale_factor,
    output logic                       mm_apply_scale,
    output logic                       mm_rst_n,
    input  logic                       mm_done,
    input  logic                       mm_error,
    output logic                       sched_busy,
    output logic [15:0]                jobs_done
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DIM = 2'b01;
    localparam logic [1:0] ST_ERR = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_CHECK, S_LAUNCH, S_WAIT, S_RESP, S_RECOVER
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [1:0]         status_q, status_d;
    logic [31:0]        rows_q, rows_d, cola_q, cola_d, colb_q, colb_d;
    logic [15:0]        scale_q, scale_d;
    logic               aps_q, aps_d;
    logic [TOW-1:0]     to_cnt_q, to_cnt_d;
    logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [15:0]        jobs_q, jobs_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               mm_enable_q, mm_enable_d;
    logic               grant_active_q, grant_active_d;
    logic               busy_q, busy_d;
    logic               mm_rst_n_q, mm_rst_n_d;

    logic [IDW-1:0]     win;
    logic [IDW-1:0]     idx_w;
    logic               found;
    logic               bad_dims;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, datapath and registered-output next values
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        status_d    = status_q;
        rows_d      = rows_q;
        cola_d      = cola_q;
        colb_d      = colb_q;
        scale_d     = scale_q;
        aps_d       = aps_q;
        to_cnt_d    = to_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        jobs_d      = jobs_q;
        req_ready_d = '0;
        win         = '0;
        idx_w       = '0;
        found       = 1'b0;

        // First requesting index at or after rr_ptr, wrapping upward
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx_w = IDW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            if (!found && req_valid[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end

        bad_dims = (rows_q == 32'd0) || (rows_q > 32'(MAX_DIM)) ||
                   (cola_q == 32'd0) || (cola_q > 32'(MAX_DIM)) ||
                   (colb_q == 32'd0) || (colb_q > 32'(MAX_DIM));

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_ACCEPT;
                    grant_d     = win;
                    status_d    = ST_OK;
                    req_ready_d = NUM_REQ'(1) << win;
                    rr_ptr_d    = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        if (win == IDW'(i)) begin
                            rows_d  = req_rows_a[i*32 +: 32];
                            cola_d  = req_cols_a[i*32 +: 32];
                            colb_d  = req_cols_b[i*32 +: 32];
                            scale_d = req_scale[i*16 +: 16];
                            aps_d   = req_apply_scale[i];
                        end
                    end
                end
            end
            S_ACCEPT: state_d = S_CHECK;
            S_CHECK: begin
                if (bad_dims) begin
                    status_d = ST_DIM;
                    state_d  = S_RESP;
                end else begin
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Error beats a simultaneous done; a done beats a coincident timeout
                if (mm_error) begin
                    status_d  = ST_ERR;
                    rst_cnt_d = '0;
                    state_d   = S_RECOVER;
                end else if (mm_done) begin
                    status_d  = ST_OK;
                    state_d   = S_RESP;
                end else if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                    status_d  = ST_TMO;
                    rst_cnt_d = '0;
                    state_d   = S_RECOVER;
                end else begin
                    to_cnt_d  = to_cnt_q + TOW'(1);
                end
            end
            S_RECOVER: begin
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = S_RESP;
                else rst_cnt_d = rst_cnt_q + RCW'(1);
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs registered from the upcoming state so they line up with it
        mm_enable_d    = (state_d == S_LAUNCH);
        grant_active_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
        busy_d         = (state_d != S_IDLE);
        mm_rst_n_d     = (state_d != S_RECOVER);
        rsp_valid_d    = (state_d == S_RESP) ? (NUM_REQ'(1) << grant_d) : '0;
        if ((state_d == S_RESP) && (status_d == ST_OK) && (jobs_q != 16'hFFFF))
            jobs_d = jobs_q + 16'd1;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            status_q       <= ST_OK;
            rows_q         <= '0;
            cola_q         <= '0;
            colb_q         <= '0;
            scale_q        <= '0;
            aps_q          <= 1'b0;
            to_cnt_q       <= '0;
            rst_cnt_q      <= '0;
            jobs_q         <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            mm_enable_q    <= 1'b0;
            grant_active_q <= 1'b0;
            busy_q         <= 1'b0;
            mm_rst_n_q     <= 1'b1;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            status_q       <= status_d;
            rows_q         <= rows_d;
            cola_q         <= cola_d;
            colb_q         <= colb_d;
            scale_q        <= scale_d;
            aps_q          <= aps_d;
            to_cnt_q       <= to_cnt_d;
            rst_cnt_q      <= rst_cnt_d;
            jobs_q         <= jobs_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            mm_enable_q    <= mm_enable_d;
            grant_active_q <= grant_active_d;
            busy_q         <= busy_d;
            mm_rst_n_q     <= mm_rst_n_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_status      = status_q;
    assign grant_id        = grant_q;
    assign grant_active    = grant_active_q;
    assign mm_enable       = mm_enable_q;
    assign mm_rows_a       = rows_q;
    assign mm_cols_a       = cola_q;
    assign mm_cols_b       = colb_q;
    assign mm_scale_factor = scale_q;
    assign mm_apply_scale  = aps_q;
    assign mm_rst_n        = mm_rst_n_q;
    assign sched_busy      = busy_q;
    assign jobs_done       = jobs_q;

endmodule

// File: tb/tb_nvdla_matmul_sched.sv
// Directed bench for nvdla_matmul_sched with a response scoreboard.
module tb_nvdla_matmul_sched;

    localparam int unsigned NR  = 4;
    localparam int unsigned TMO = 50;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DIM = 2'b01;
    localparam logic [1:0] ST_ERR = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_rows_a, req_cols_a, req_cols_b;
    logic [NR*16-1:0]  req_scale;
    logic [NR-1:0]     req_apply_scale;
    logic [NR-1:0]     rsp_valid;
    logic [1:0]        rsp_status;
    logic [1:0]        grant_id;
    logic              grant_active, mm_enable, mm_apply_scale, mm_rst_n;
    logic [31:0]       mm_rows_a, mm_cols_a, mm_cols_b;
    logic [15:0]       mm_scale_factor, jobs_done;
    logic              mm_done, mm_error, sched_busy;

    logic [31:0] rows [NR];
    logic [31:0] ca   [NR];
    logic [31:0] cb   [NR];

    typedef struct {
        int         id;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   exp_jobs = 0;
    int   n;
    int   lo;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NR); i++) begin
            req_rows_a[i*32 +: 32] = rows[i];
            req_cols_a[i*32 +: 32] = ca[i];
            req_cols_b[i*32 +: 32] = cb[i];
            req_scale[i*16 +: 16]  = 16'h0100 + 16'(i);
        end
        req_apply_scale = 4'b0101;
    end

    nvdla_matmul_sched #(
        .NUM_REQ(NR), .MAX_DIM(256), .TIMEOUT_CYCLES(TMO), .RST_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rows_a(req_rows_a), .req_cols_a(req_cols_a), .req_cols_b(req_cols_b),
        .req_scale(req_scale), .req_apply_scale(req_apply_scale),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .grant_id(grant_id), .grant_active(grant_active),
        .mm_enable(mm_enable), .mm_rows_a(mm_rows_a), .mm_cols_a(mm_cols_a),
        .mm_cols_b(mm_cols_b), .mm_scale_factor(mm_scale_factor),
        .mm_apply_scale(mm_apply_scale), .mm_rst_n(mm_rst_n),
        .mm_done(mm_done), .mm_error(mm_error),
        .sched_busy(sched_busy), .jobs_done(jobs_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [1:0] st);
        exp_t e;
        e.id = id;
        e.st = st;
        sb.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},    32'(req_ready),       32'd0);
        chk({tag, "_rsp_valid"},    32'(rsp_valid),       32'd0);
        chk({tag, "_rsp_status"},   32'(rsp_status),      32'd0);
        chk({tag, "_grant_id"},     32'(grant_id),        32'd0);
        chk({tag, "_grant_active"}, 32'(grant_active),    32'd0);
        chk({tag, "_mm_enable"},    32'(mm_enable),       32'd0);
        chk({tag, "_busy"},         32'(sched_busy),      32'd0);
        chk({tag, "_rows"},         mm_rows_a,            32'd0);
        chk({tag, "_cols_a"},       mm_cols_a,            32'd0);
        chk({tag, "_cols_b"},       mm_cols_b,            32'd0);
        chk({tag, "_scale"},        32'(mm_scale_factor), 32'd0);
        chk({tag, "_apply"},        32'(mm_apply_scale),  32'd0);
        chk({tag, "_mm_rst_n"},     32'(mm_rst_n),        32'd1);
        chk({tag, "_jobs"},         32'(jobs_done),       32'd0);
    endtask

    // Compare the response present this cycle against the scoreboard head
    task automatic check_rsp_now(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 32'(rsp_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd1 << e.id);
            chk({tag, "_rsp_status"}, 32'(rsp_status), 32'(e.st));
            if (e.st == ST_OK) exp_jobs++;
            chk({tag, "_jobs_done"},  32'(jobs_done),  32'(exp_jobs));
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (rsp_valid == '0 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (rsp_valid == '0) chk({tag, "_rsp_arrived"}, 32'd0, 32'd1);
        else check_rsp_now(tag);
    endtask

    task automatic wait_grant(input string tag, input int id, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (req_ready == '0 && cyc < budget);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1 << id);
        chk({tag, "_grant_id"},  32'(grant_id),  32'(id));
    endtask

    task automatic wait_launch(input string tag, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!mm_enable && cyc < budget);
        chk({tag, "_mm_enable"}, 32'(mm_enable), 32'd1);
    endtask

    task automatic count_rst_low(output int cnt);
        cnt = 0;
        while (mm_rst_n == 1'b0 && cnt < 10) begin
            cnt++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        mm_done   = 1'b0;
        mm_error  = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        exp_jobs = 0;
        sb.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        mm_done   = 1'b0;
        mm_error  = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            rows[i] = 32'd8;
            ca[i]   = 32'd8;
            cb[i]   = 32'd8;
        end
        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Single job on requester 1
        rows[1] = 32'd4; ca[1] = 32'd8; cb[1] = 32'd4;
        req_valid[1] = 1'b1;
        push(1, ST_OK);
        wait_grant("t1", 1, 4, n);
        chk("t1_ready_latency", 32'(n), 32'd1);
        req_valid[1] = 1'b0;
        chk("t1_rows", mm_rows_a, 32'd4);
        chk("t1_cols_a", mm_cols_a, 32'd8);
        chk("t1_cols_b", mm_cols_b, 32'd4);
        chk("t1_scale", 32'(mm_scale_factor), 32'h0101);
        chk("t1_apply", 32'(mm_apply_scale), 32'd0);
        wait_launch("t1", 6, n);
        chk("t1_enable_latency", 32'(n), 32'd2);
        chk("t1_grant_active", 32'(grant_active), 32'd1);
        tick();
        chk("t1_enable_pulse", 32'(mm_enable), 32'd0);
        chk("t1_wait_active", 32'(grant_active), 32'd1);
        chk("t1_busy", 32'(sched_busy), 32'd1);
        repeat (18) tick();
        chk("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        mm_done = 1'b1;
        wait_rsp("t1", 3, n);
        mm_done = 1'b0;
        chk("t1_done_latency", 32'(n), 32'd1);

        // Round-robin with every requester continuously valid
        do_reset();
        for (int i = 0; i < int'(NR); i++) begin
            rows[i] = 32'd16; ca[i] = 32'd16; cb[i] = 32'd16;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            push(k % int'(NR), ST_OK);
            wait_grant("t2", k % int'(NR), 6, n);
            wait_launch("t2", 6, n);
            repeat (3) tick();
            mm_done = 1'b1;
            wait_rsp("t2", 3, n);
            mm_done = 1'b0;
        end
        req_valid = '0;

        // Bad dimensions on requester 2
        rows[2] = 32'd4; ca[2] = 32'd0; cb[2] = 32'd4;
        for (int t = 0; t < 2; t++) begin
            req_valid[2] = 1'b1;
            push(2, ST_DIM);
            wait_grant("t3", 2, 6, n);
            req_valid[2] = 1'b0;
            tick();
            chk("t3_check_no_enable", 32'(mm_enable), 32'd0);
            chk("t3_check_no_rsp", 32'(rsp_valid), 32'd0);
            wait_rsp("t3", 3, n);
            chk("t3_rsp_latency", 32'(n), 32'd1);
            chk("t3_rsp_no_enable", 32'(mm_enable), 32'd0);
            ca[2] = 32'd8;
            cb[2] = 32'd257;
        end
        chk("t3_cols_b_held", mm_cols_b, 32'd257);

        // Multiplier error and recovery, then a normal job
        rows[0] = 32'd256; ca[0] = 32'd1; cb[0] = 32'd2;
        req_valid[0] = 1'b1;
        push(0, ST_ERR);
        wait_grant("t4", 0, 6, n);
        req_valid[0] = 1'b0;
        wait_launch("t4", 6, n);
        repeat (4) tick();
        mm_error = 1'b1;
        tick();
        mm_error = 1'b0;
        count_rst_low(lo);
        chk("t4_rst_low_cycles", 32'(lo), 32'd2);
        check_rsp_now("t4");

        req_valid[3] = 1'b1;
        push(3, ST_OK);
        wait_grant("t4b", 3, 6, n);
        req_valid[3] = 1'b0;
        wait_launch("t4b", 6, n);
        chk("t4b_rst_n_high", 32'(mm_rst_n), 32'd1);
        repeat (2) tick();
        mm_done = 1'b1;
        wait_rsp("t4b", 3, n);
        mm_done = 1'b0;

        // Done and error together: error wins
        req_valid[1] = 1'b1;
        rows[1] = 32'd8; ca[1] = 32'd8; cb[1] = 32'd8;
        push(1, ST_ERR);
        wait_grant("t4c", 1, 6, n);
        req_valid[1] = 1'b0;
        wait_launch("t4c", 6, n);
        tick();
        mm_done  = 1'b1;
        mm_error = 1'b1;
        tick();
        mm_done  = 1'b0;
        mm_error = 1'b0;
        count_rst_low(lo);
        chk("t4c_rst_low_cycles", 32'(lo), 32'd2);
        check_rsp_now("t4c");

        // Timeout: mm_done never arrives
        req_valid[2] = 1'b1;
        ca[2] = 32'd8; cb[2] = 32'd8;
        push(2, ST_TMO);
        wait_grant("t5", 2, 6, n);
        req_valid[2] = 1'b0;
        wait_launch("t5", 6, n);
        n = 0;
        while (mm_rst_n == 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("t5_rst_low_time", 32'((n >= 50) && (n <= 52)), 32'd1);
        chk("t5_status_at_recover", 32'(rsp_status), 32'(ST_TMO));
        count_rst_low(lo);
        chk("t5_rst_low_cycles", 32'(lo), 32'd2);
        check_rsp_now("t5");

        // Reset during WAIT aborts the job
        req_valid[2] = 1'b1;
        wait_grant("t6", 2, 6, n);
        req_valid[2] = 1'b0;
        wait_launch("t6", 6, n);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6");
        rows[3] = 32'd2; ca[3] = 32'd2; cb[3] = 32'd2;
        req_valid[3] = 1'b1;
        tick();
        tick();
        chk("t6_no_rsp_in_reset", 32'(rsp_valid), 32'd0);
        rst_n    = 1'b1;
        exp_jobs = 0;
        push(3, ST_OK);
        wait_grant("t6b", 3, 4, n);
        chk("t6b_ready_latency", 32'(n), 32'd1);
        req_valid[3] = 1'b0;
        wait_launch("t6b", 6, n);
        repeat (2) tick();
        mm_done = 1'b1;
        wait_rsp("t6b", 3, n);
        mm_done = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
